// File: rtl/panel_peaton.sv
// ============================================================================
//  Module      : panel_peaton
//  Description : Pedestrian panel: debounced request button plus walk,
//                don't-walk, flashing-warning and wait lamps that follow the
//                crossing controller's red/amber/green lamps.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module panel_peaton #(
    parameter int N_ANTIRREBOTE    = 4,
    parameter int T_CRUCE          = 11,
    parameter int T_AVISO          = 4,
    parameter int T_MEDIO_PARPADEO = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic boton_raw,
    input  logic rojo,
    input  logic amarillo,
    input  logic verde,
    output logic pulsador,
    output logic espera,
    output logic camine,
    output logic no_camine,
    output logic falla
);

    localparam int c_W_DEB = $clog2(N_ANTIRREBOTE + 1);
    localparam int c_W_CNT = $clog2(T_CRUCE + 1);
    localparam int c_W_BLK = $clog2(T_MEDIO_PARPADEO + 1);

    localparam logic [c_W_DEB-1:0] c_DEB_MAX   = c_W_DEB'(N_ANTIRREBOTE - 1);
    localparam logic [c_W_CNT-1:0] c_CNT_MAX   = c_W_CNT'(T_CRUCE);
    // Compared against the pre-increment count, so AVISO starts when cnt reaches T_CRUCE-T_AVISO
    localparam logic [c_W_CNT-1:0] c_AVISO_IDX = c_W_CNT'(T_CRUCE - T_AVISO - 1);
    localparam logic [c_W_BLK-1:0] c_BLK_MAX   = c_W_BLK'(T_MEDIO_PARPADEO - 1);

    typedef enum logic [1:0] {
        REPOSO = 2'd0,
        ESPERA = 2'd1,
        CRUCE  = 2'd2,
        AVISO  = 2'd3
    } state_t;

    logic               r_sync1;
    logic               r_sync2;
    logic               r_estable;
    logic               r_estable_d;
    logic [c_W_DEB-1:0] r_deb_cnt;
    logic               r_rojo_d;

    state_t             r_state;
    logic [c_W_CNT-1:0] r_cnt;
    logic [c_W_BLK-1:0] r_blk;
    logic               r_pulsador;
    logic               r_espera;
    logic               r_camine;
    logic               r_no_camine;
    logic               r_falla;

    state_t             w_state_nx;
    logic [c_W_CNT-1:0] w_cnt_nx;
    logic [c_W_BLK-1:0] w_blk_nx;
    logic               w_pulsador_nx;
    logic               w_espera_nx;
    logic               w_camine_nx;
    logic               w_no_camine_nx;

    logic               w_press;
    logic               w_rojo_sube;
    logic               w_legal;
    logic [c_W_CNT-1:0] w_cnt_inc;

    // Synchroniser and debouncer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1     <= 1'b0;
            r_sync2     <= 1'b0;
            r_estable   <= 1'b0;
            r_estable_d <= 1'b0;
            r_deb_cnt   <= '0;
            r_rojo_d    <= 1'b0;
        end else begin
            r_sync1     <= boton_raw;
            r_sync2     <= r_sync1;
            r_estable_d <= r_estable;
            r_rojo_d    <= rojo;
            if (r_sync2 != r_estable) begin
                if (r_deb_cnt == c_DEB_MAX) begin
                    r_estable <= r_sync2;
                    r_deb_cnt <= '0;
                end else begin
                    r_deb_cnt <= r_deb_cnt + 1'b1;
                end
            end else begin
                r_deb_cnt <= '0;
            end
        end
    end

    assign w_press     = r_estable & ~r_estable_d;
    assign w_rojo_sube = rojo & ~r_rojo_d;
    assign w_legal     = ( rojo & ~amarillo & ~verde) |
                         (~rojo &  amarillo & ~verde) |
                         (~rojo & ~amarillo &  verde);
    assign w_cnt_inc   = (r_cnt == c_CNT_MAX) ? r_cnt : r_cnt + 1'b1;

    always_comb begin
        w_state_nx     = r_state;
        w_cnt_nx       = r_cnt;
        w_blk_nx       = r_blk;
        w_pulsador_nx  = 1'b0;
        w_espera_nx    = r_espera;
        w_camine_nx    = 1'b0;
        w_no_camine_nx = 1'b1;

        case (r_state)
            REPOSO: begin
                if (w_rojo_sube) begin
                    w_state_nx     = CRUCE;
                    w_cnt_nx       = '0;
                    w_espera_nx    = 1'b0;
                    w_camine_nx    = 1'b1;
                    w_no_camine_nx = 1'b0;
                end else if (w_press) begin
                    w_state_nx    = ESPERA;
                    w_pulsador_nx = 1'b1;
                    w_espera_nx   = 1'b1;
                end
            end
            ESPERA: begin
                if (w_rojo_sube) begin
                    w_state_nx     = CRUCE;
                    w_cnt_nx       = '0;
                    w_espera_nx    = 1'b0;
                    w_camine_nx    = 1'b1;
                    w_no_camine_nx = 1'b0;
                end
            end
            CRUCE: begin
                if (!rojo) begin
                    w_state_nx = REPOSO;
                end else begin
                    w_cnt_nx       = w_cnt_inc;
                    w_camine_nx    = 1'b1;
                    w_no_camine_nx = 1'b0;
                    if (r_cnt == c_AVISO_IDX) begin
                        w_state_nx = AVISO;
                        w_blk_nx   = '0;
                    end
                end
            end
            AVISO: begin
                if (!rojo) begin
                    w_state_nx = REPOSO;
                end else begin
                    w_cnt_nx       = w_cnt_inc;
                    w_no_camine_nx = 1'b0;
                    if (r_blk == c_BLK_MAX) begin
                        w_blk_nx    = '0;
                        w_camine_nx = ~r_camine;
                    end else begin
                        w_blk_nx    = r_blk + 1'b1;
                        w_camine_nx = r_camine;
                    end
                end
            end
            default: w_state_nx = REPOSO;
        endcase

        // An illegal lamp pattern blanks the walk lamp; a request pulse may still go out
        if (!w_legal) begin
            w_state_nx     = REPOSO;
            w_cnt_nx       = '0;
            w_espera_nx    = r_espera;
            w_camine_nx    = 1'b0;
            w_no_camine_nx = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= REPOSO;
            r_cnt       <= '0;
            r_blk       <= '0;
            r_pulsador  <= 1'b0;
            r_espera    <= 1'b0;
            r_camine    <= 1'b0;
            r_no_camine <= 1'b1;
            r_falla     <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_cnt       <= w_cnt_nx;
            r_blk       <= w_blk_nx;
            r_pulsador  <= w_pulsador_nx;
            r_espera    <= w_espera_nx;
            r_camine    <= w_camine_nx;
            r_no_camine <= w_no_camine_nx;
            r_falla     <= ~w_legal;
        end
    end

    assign pulsador  = r_pulsador;
    assign espera    = r_espera;
    assign camine    = r_camine;
    assign no_camine = r_no_camine;
    assign falla     = r_falla;

endmodule

`default_nettype wire
